// File: rtl/traceback_ctrl.sv
// Traceback sequencer over a circular survivor memory: latches write row and best state,
// walks TB_LEN rows backwards and presents the decoded bit on valid/ready. Option macro: TB_OVERRUN_CNT_EN.
module traceback_ctrl #(
  parameter int K      = 5,
  parameter int M      = K - 1,
  parameter int S      = 1 << M,
  parameter int D      = 10,
  parameter int TB_LEN = D - 1,
  localparam int AW    = $clog2(D),
  localparam int CW    = $clog2(TB_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_ptr,
  input  logic [M-1:0]  best_state,
  output logic [AW-1:0] rd_time,
  output logic [M-1:0]  rd_state,
  input  logic          surv_bit,
  output logic          out_bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          overrun
`ifdef TB_OVERRUN_CNT_EN
  ,
  output logic [7:0]    overrun_cnt
`endif
);

  if (TB_LEN < 1 || TB_LEN > D - 1 || S != (1 << M) || M < 2) begin : g_bad_cfg
    $error("traceback_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, TRACE, OUTPUT} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] rd_time_q, rd_time_d;
  logic [M-1:0]  rd_state_q, rd_state_d;
  logic [CW-1:0] step_q, step_d;
  logic [CW-1:0] fill_q, fill_d;
  logic          out_bit_q, out_bit_d;
  logic          overrun_q, overrun_d;
  logic          trig;

  // The trigger counts the write happening this cycle toward the fill level.
  assign trig = wr_en && ((int'(fill_q) + 1) >= TB_LEN);

  always_comb begin
    state_d    = state_q;
    rd_time_d  = rd_time_q;
    rd_state_d = rd_state_q;
    step_d     = step_q;
    fill_d     = fill_q;
    out_bit_d  = out_bit_q;
    overrun_d  = overrun_q;

    if (wr_en && fill_q != CW'(TB_LEN)) fill_d = fill_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d    = TRACE;
          rd_time_d  = wr_ptr;
          rd_state_d = best_state;
          step_d     = '0;
        end
      end
      TRACE: begin
        // One extra cycle after the last step so out_bit comes from the settled state.
        if (step_q == CW'(TB_LEN)) begin
          state_d   = OUTPUT;
          out_bit_d = rd_state_q[M-1];
        end else begin
          rd_state_d = {rd_state_q[M-2:0], surv_bit};
          rd_time_d  = (rd_time_q == '0) ? AW'(D - 1) : rd_time_q - 1'b1;
          step_d     = step_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (trig && state_q != IDLE) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_time_q  <= '0;
      rd_state_q <= '0;
      step_q     <= '0;
      fill_q     <= '0;
      out_bit_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_time_q  <= rd_time_d;
      rd_state_q <= rd_state_d;
      step_q     <= step_d;
      fill_q     <= fill_d;
      out_bit_q  <= out_bit_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef TB_OVERRUN_CNT_EN
  logic [7:0] ocnt_q, ocnt_d;

  always_comb begin
    ocnt_d = ocnt_q;
    if (trig && state_q != IDLE && ocnt_q != 8'hFF) ocnt_d = ocnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ocnt_q <= '0;
    else        ocnt_q <= ocnt_d;
  end

  assign overrun_cnt = ocnt_q;
`endif

  assign rd_time   = rd_time_q;
  assign rd_state  = rd_state_q;
  assign out_bit   = out_bit_q;
  assign out_valid = (state_q == OUTPUT);
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_traceback_ctrl.sv
// Scoreboard bench for traceback_ctrl: a snapshot traceback model predicts the read path and
// decoded bit at trigger time; a negedge monitor compares DUT outputs against it.
module tb_traceback_ctrl;
  localparam int M = 4, S = 16, D = 10, TB_LEN = 9, AW = 4;

  logic          clk = 1'b0, rst_n = 1'b1, wr_en = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] wr_ptr = '0, rd_time;
  logic [M-1:0]  best_state = '0, rd_state;
  logic          surv_bit, out_bit, out_valid, busy, overrun;
`ifdef TB_OVERRUN_CNT_EN
  logic [7:0]    overrun_cnt;
`endif

  logic [S-1:0]  mem [D];
  logic [S-1:0]  row = '0;

  // model state
  int            fill, m_cnt, m_ocnt, ptr_next;
  bit            m_busy, m_wrote, m_ovr, chk_en;
  logic [AW-1:0] e_t;
  logic [M-1:0]  e_st;
  logic [AW-1:0] path_t [TB_LEN+1];
  logic [M-1:0]  path_st [TB_LEN+1];
  bit            q [$];
  int            n_chk, n_fail;

  traceback_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ptr(wr_ptr), .best_state(best_state),
    .rd_time(rd_time), .rd_state(rd_state), .surv_bit(surv_bit), .out_bit(out_bit),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overrun(overrun)
`ifdef TB_OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign surv_bit = mem[rd_time][rd_state];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fill = 0; m_cnt = 0; m_ocnt = 0; m_busy = 0; m_wrote = 0; m_ovr = 0;
    e_t = '0; e_st = '0;
    q.delete();
  endtask

  task automatic start_trace();
    path_t[0]  = wr_ptr;
    path_st[0] = best_state;
    for (int i = 1; i <= TB_LEN; i++) begin
      path_st[i] = M'((int'(path_st[i-1]) * 2 + int'(mem[path_t[i-1]][path_st[i-1]])) % S);
      path_t[i]  = AW'((int'(path_t[i-1]) + D - 1) % D);
    end
    q.push_back(path_st[TB_LEN][M-1]);
    m_busy = 1; m_cnt = 0; m_wrote = 0;
  endtask

  // Applies the inputs the DUT sampled on this rising edge.
  task automatic model_edge();
    bit trig, was_busy, hs;
    trig = wr_en && (fill + 1 >= TB_LEN);
    if (wr_en && fill < TB_LEN) fill++;
    if (wr_en) begin
      mem[wr_ptr] = row;
      if (m_busy) m_wrote = 1;
      ptr_next = (ptr_next + 1) % D;
    end
    was_busy = m_busy;
    hs = m_busy && m_cnt > TB_LEN && out_ready;
    if (m_busy) begin
      if (hs) m_busy = 0;
      else if (m_cnt <= TB_LEN) m_cnt++;
    end
    if (trig && was_busy) begin
      m_ovr = 1;
      if (m_ocnt < 255) m_ocnt++;
    end else if (trig) start_trace();
    if (m_busy) begin
      e_t  = path_t[(m_cnt > TB_LEN) ? TB_LEN : m_cnt];
      e_st = path_st[(m_cnt > TB_LEN) ? TB_LEN : m_cnt];
    end
  endtask

  // Only one write is allowed per traceback so rows still to be read stay intact.
  task automatic drive(input int mode, input int p_wr, input int p_rdy);
    wr_en     = ($urandom_range(99) < p_wr) && !(m_busy && m_wrote);
    wr_ptr    = AW'(ptr_next);
    row       = (mode == 1) ? '0 : (mode == 2) ? '1 : S'($urandom);
    best_state = (mode == 1) ? 4'b1010 : (mode == 2) ? 4'b0000 : M'($urandom);
    out_ready = ($urandom_range(99) < p_rdy);
  endtask

  task automatic run(input int mode, input int p_wr, input int p_rdy, input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1 drive(mode, p_wr, p_rdy);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " rd_time"}, int'(rd_time), 0);
    check({tag, " rd_state"}, int'(rd_state), 0);
    check({tag, " out_bit"}, int'(out_bit), 0);
    check({tag, " out_valid"}, int'(out_valid), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " overrun"}, int'(overrun), 0);
`ifdef TB_OVERRUN_CNT_EN
    check({tag, " overrun_cnt"}, int'(overrun_cnt), 0);
`endif
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), int'(m_busy));
      check("out_valid", int'(out_valid), int'(m_busy && m_cnt > TB_LEN));
      check("overrun", int'(overrun), int'(m_ovr));
      check("rd_time", int'(rd_time), int'(e_t));
      check("rd_state", int'(rd_state), int'(e_st));
`ifdef TB_OVERRUN_CNT_EN
      check("overrun_cnt", int'(overrun_cnt), m_ocnt);
`endif
      if (out_valid) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL out_bit: valid with no expected result at %0t", $time);
        end else begin
          check("out_bit", int'(out_bit), int'(q[0]));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    bit hit;
    n_chk = 0; n_fail = 0; chk_en = 0; ptr_next = 0;
    for (int i = 0; i < D; i++) mem[i] = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1;

    // zero rows, best 1010; long stall with one overlapping trigger
    run(1, 100, 0, 30);
    run(1, 0, 100, 3);
    // one rows, best 0000
    run(2, 100, 100, 30);
    run(2, 0, 100, 5);
    // random traffic with backpressure
    run(0, 50, 60, 3000);

    // reset in the middle of a traceback
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      run(0, 100, 50, 1);
      hit = m_busy && (m_cnt == 3);
    end
    if (!hit) begin
      n_chk++; n_fail++;
      $display("FAIL mid_reset: traceback step 3 not reached within bound");
    end
    #1 rst_n = 1'b0;
    chk_en = 0;
    wr_en = 1'b0;
    #1 check_zero("mid_reset");
    model_reset();
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1;
    run(0, 100, 100, 40);
    run(0, 60, 40, 2000);

    run(0, 0, 100, 30);
    check("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
